// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step-counter width: enough bits to count N iterations.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to subtract.
module div_step #(
  parameter int unsigned N = 8
) (
  input  logic [N:0]   rem,
  input  logic         quo_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_next,
  output logic         q_bit
);

  logic [N+1:0] shifted;
  logic [N+1:0] trial;

  // One guard bit above the shifted remainder turns the trial MSB into a borrow flag.
  always_comb begin
    shifted  = {rem, quo_msb};
    trial    = shifted - (N+2)'(divisor);
    q_bit    = ~trial[N+1];
    rem_next = q_bit ? trial[N:0] : shifted[N:0];
  end

endmodule

// File: rtl/divider_n_bits_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module divider_n_bits_seq
  import divider_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int unsigned CW = cnt_width(N);

  state_t         state_q, state_d;
  logic [N:0]     rem_q, rem_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_d, r_d;
  logic           dz_d;
  logic [N:0]     step_rem;
  logic           step_bit;
  logic           last_step_c;

  div_step #(.N(N)) u_step (
    .rem      (rem_q),
    .quo_msb  (quo_q[N-1]),
    .divisor  (div_q),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  assign last_step_c = (cnt_q == CW'(N - 1));

  // State register plus all datapath and output registers.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      Q        <= q_d;
      R        <= r_d;
      div_zero <= dz_d;
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
    end
  end

  // Next-state logic; a zero divisor skips RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (B == '0) ? DONE : RUN;
      RUN:     if (last_step_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result-register next values.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    cnt_d = cnt_q;
    q_d   = Q;
    r_d   = R;
    dz_d  = div_zero;
    case (state_q)
      IDLE: begin
        if (start) begin
          quo_d = A;
          div_d = B;
          rem_d = '0;
          cnt_d = '0;
          if (B == '0) begin
            q_d  = '1;
            r_d  = A;
            dz_d = 1'b1;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = N'({quo_q, step_bit});
        cnt_d = cnt_q + CW'(1);
        if (last_step_c) begin
          q_d  = quo_d;
          r_d  = step_rem[N-1:0];
          dz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_divider_n_bits_seq.sv
// Directed and swept checks for the sequential restoring divider (N=8).
module tb_divider_n_bits_seq;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         aclr;
  logic         start;
  logic [N-1:0] a, b, q, r;
  logic         busy, done, div_zero;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  divider_n_bits_seq #(.N(N)) dut (
    .clk      (clk),
    .aclr     (aclr),
    .start    (start),
    .A        (a),
    .B        (b),
    .Q        (q),
    .R        (r),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // Issue a one-cycle start from a negedge and wait (bounded) for done.
  task automatic run_div(input logic [N-1:0] av, input logic [N-1:0] bv,
                         output int lat, output int bcnt, output bit tmo);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0; tmo = 1'b0;
    forever begin
      if (busy) bcnt++;
      if (done) break;
      if (lat >= 40) begin tmo = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    aclr = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    vectors++; if (q !== 8'd0) begin miscompares++; $display("FAIL reset_q got %0d want 0", q); end
    vectors++; if (r !== 8'd0) begin miscompares++; $display("FAIL reset_r got %0d want 0", r); end
    vectors++; if ({busy, done, div_zero} !== 3'b000) begin miscompares++;
      $display("FAIL reset_flags got busy/done/dz=%b want 000", {busy, done, div_zero}); end
    aclr = 1'b1;
    @(negedge clk);
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++;
      $display("FAIL post_reset_idle got busy/done=%b want 00", {busy, done}); end
  endtask

  task automatic test_basic();
    int lat, bcnt; bit tmo;
    run_div(8'd200, 8'd7, lat, bcnt, tmo);
    vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL basic_timeout got no done want done"); end
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL basic_latency got %0d want 9", lat); end
    vectors++; if (bcnt !== 9) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 9", bcnt); end
    vectors++; if (q !== 8'd28) begin miscompares++; $display("FAIL basic_q got %0d want 28", q); end
    vectors++; if (r !== 8'd4) begin miscompares++; $display("FAIL basic_r got %0d want 4", r); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL basic_dz got %b want 0", div_zero); end
    @(negedge clk);
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++;
      $display("FAIL basic_after got busy/done=%b want 00", {busy, done}); end
    vectors++; if (q !== 8'd28) begin miscompares++; $display("FAIL basic_hold_q got %0d want 28", q); end
  endtask

  task automatic test_boundaries();
    logic [N-1:0] va [4] = '{8'd255, 8'd3,  8'd0, 8'd255};
    logic [N-1:0] vb [4] = '{8'd1,   8'd10, 8'd5, 8'd255};
    logic [N-1:0] eq [4] = '{8'd255, 8'd0,  8'd0, 8'd1};
    logic [N-1:0] er [4] = '{8'd0,   8'd3,  8'd0, 8'd0};
    int lat, bcnt; bit tmo;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], lat, bcnt, tmo);
      vectors++; if (tmo !== 1'b0 || lat !== 9) begin miscompares++;
        $display("FAIL bound%0d_latency got %0d (timeout=%b) want 9", i, lat, tmo); end
      vectors++; if (q !== eq[i]) begin miscompares++;
        $display("FAIL bound%0d_q %0d/%0d got %0d want %0d", i, va[i], vb[i], q, eq[i]); end
      vectors++; if (r !== er[i]) begin miscompares++;
        $display("FAIL bound%0d_r %0d/%0d got %0d want %0d", i, va[i], vb[i], r, er[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt; bit tmo;
    run_div(8'd5, 8'd0, lat, bcnt, tmo);
    vectors++; if (tmo !== 1'b0 || lat !== 1) begin miscompares++;
      $display("FAIL dz_latency got %0d (timeout=%b) want 1", lat, tmo); end
    vectors++; if (bcnt !== 1) begin miscompares++; $display("FAIL dz_busy_cycles got %0d want 1", bcnt); end
    vectors++; if (q !== 8'd255) begin miscompares++; $display("FAIL dz_q got %0d want 255", q); end
    vectors++; if (r !== 8'd5) begin miscompares++; $display("FAIL dz_r got %0d want 5", r); end
    vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL dz_flag got %b want 1", div_zero); end
    @(negedge clk);
    vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL dz_hold got %b want 1", div_zero); end
    run_div(8'd9, 8'd3, lat, bcnt, tmo);
    vectors++; if (tmo !== 1'b0 || lat !== 9) begin miscompares++;
      $display("FAIL dz_next_latency got %0d (timeout=%b) want 9", lat, tmo); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL dz_clear got %b want 0", div_zero); end
    vectors++; if (q !== 8'd3) begin miscompares++; $display("FAIL dz_next_q got %0d want 3", q); end
    vectors++; if (r !== 8'd0) begin miscompares++; $display("FAIL dz_next_r got %0d want 0", r); end
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    int lat, ndone;
    a = 8'd100; b = 8'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (3) begin @(negedge clk); lat++; end
    a = 8'd50; b = 8'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat++;
    start = 1'b0; a = 8'd0; b = 8'd0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL busy_start_latency got %0d want 9", lat); end
    vectors++; if (q !== 8'd11) begin miscompares++; $display("FAIL busy_start_q got %0d want 11", q); end
    vectors++; if (r !== 8'd1) begin miscompares++; $display("FAIL busy_start_r got %0d want 1", r); end
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done) ndone++; end
    vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL busy_start_dropped got %0d extra done want 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int t, n, tdone [4];
    a = 8'd100; b = 8'd9; start = 1'b1;
    n = 0;
    for (t = 0; t < 60 && n < 4; t++) begin
      @(negedge clk);
      if (done) begin
        tdone[n] = t;
        n++;
        vectors++; if (q !== 8'd11 || r !== 8'd1) begin miscompares++;
          $display("FAIL b2b_result%0d got q=%0d r=%0d want q=11 r=1", n, q, r); end
      end
    end
    start = 1'b0;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL b2b_count got %0d done pulses want 4", n); end
    for (int i = 1; i < n; i++) begin
      vectors++; if (tdone[i] - tdone[i-1] !== 10) begin miscompares++;
        $display("FAIL b2b_period%0d got %0d want 10", i, tdone[i] - tdone[i-1]); end
    end
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_abort();
    int ndone;
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 aclr = 1'b0;
    #1;
    vectors++; if ({busy, done, div_zero} !== 3'b000) begin miscompares++;
      $display("FAIL abort_flags got busy/done/dz=%b want 000", {busy, done, div_zero}); end
    vectors++; if (q !== 8'd0 || r !== 8'd0) begin miscompares++;
      $display("FAIL abort_qr got q=%0d r=%0d want 0 0", q, r); end
    @(negedge clk);
    aclr = 1'b1;
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done) ndone++; end
    vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL abort_no_done got %0d done want 0", ndone); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    logic [N-1:0] av, bv;
    int lat, bcnt; bit tmo;
    for (int i = 0; i < 1000; i++) begin
      av = N'($urandom_range(0, 255));
      bv = N'($urandom_range(1, 255));
      run_div(av, bv, lat, bcnt, tmo);
      vectors++;
      if (tmo !== 1'b0 || q !== av / bv || r !== av % bv || div_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d %0d/%0d got q=%0d r=%0d dz=%b timeout=%b want q=%0d r=%0d dz=0",
                 i, av, bv, q, r, div_zero, tmo, av / bv, av % bv);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_start_busy();
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
